// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared state type and pointer helper for the round-robin mux
package rr_mux_pkg;

    typedef enum logic {ARB, LOCK} rr_state_t;

    function automatic int next_ptr(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_mux_arb.sv
// rr_arb_m: combinational rotating-priority arbiter, first request at or after ptr wins
module rr_arb_m #(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    int idx;

    // Scan from the farthest offset down so the nearest request overwrites the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_CH;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux_m.sv
// rr_mux_m: registered N-channel round-robin mux; RR_MUX_LOCK_EN adds packet lock via in_last/out_last
module rr_mux_m
    import rr_mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_CH  = 4,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*WIDTH-1:0]  in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
`ifdef RR_MUX_LOCK_EN
    input  logic [N_CH-1:0]        in_last,
    output logic                   out_last,
`endif
    output logic [WIDTH-1:0]       out_data,
    output logic [CH_W-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] sel;
    logic [CH_W-1:0] arb_idx;
    logic [N_CH-1:0] grant;
    logic [N_CH-1:0] arb_grant;
    logic            load;
    logic            accept;

    rr_arb_m #(.N_CH(N_CH)) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

`ifdef RR_MUX_LOCK_EN
    rr_state_t       state;
    logic [CH_W-1:0] lock_ch;
    // A locked channel keeps the grant even when idle, so gaps stall rather than switch.
    assign sel   = (state == LOCK) ? lock_ch : arb_idx;
    assign grant = (state == LOCK) ? N_CH'(1) << lock_ch : arb_grant;
`else
    assign sel   = arb_idx;
    assign grant = arb_grant;
`endif

    assign load     = !out_valid || out_ready;
    assign in_ready = grant & {N_CH{load && rst_n}};
    assign accept   = |(in_valid & in_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
`ifdef RR_MUX_LOCK_EN
            out_last  <= 1'b0;
            state     <= ARB;
            lock_ch   <= '0;
`endif
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data[sel*WIDTH +: WIDTH];
                out_ch    <= sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef RR_MUX_LOCK_EN
            if (accept) begin
                out_last <= in_last[sel];
                if (!in_last[sel]) begin
                    state   <= LOCK;
                    lock_ch <= sel;
                end else begin
                    state <= ARB;
                    ptr   <= CH_W'(next_ptr(int'(sel), N_CH));
                end
            end
`else
            if (accept)
                ptr <= CH_W'(next_ptr(int'(sel), N_CH));
`endif
        end
    end

endmodule

// File: tb/tb_rr_mux_m.sv
// tb_rr_mux_m: self-checking bench for rr_mux_m with a behavioural round-robin model
module tb_rr_mux_m;

    localparam int W = 8;
    localparam int N = 4;
`ifdef RR_MUX_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   in_last = '1;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_valid;
    logic           out_ready = 1'b0;
`ifdef RR_MUX_LOCK_EN
    logic           out_last;
`endif

    int checks = 0;
    int errors = 0;

    int           m_ptr, m_ch, m_lock_ch;
    bit           m_valid, m_last, m_lock;
    logic [W-1:0] m_data;
    logic [N-1:0] m_rdy;

    rr_mux_m #(.WIDTH(W), .N_CH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef RR_MUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Nearest valid channel at or after p, measured as forward distance around the ring.
    function automatic int pick(input logic [N-1:0] v, input int p);
        int best = -1;
        int bd = N;
        for (int i = 0; i < N; i++)
            if (v[i] && (i - p + N) % N < bd) begin
                bd = (i - p + N) % N;
                best = i;
            end
        return best;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_data = '0; m_ch = 0; m_last = 0; m_lock = 0; m_lock_ch = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for this cycle, predict in_ready now and the registered result after the edge.
    task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic [N-1:0] l, input logic r);
        int g;
        bit ld;
        in_valid = v; in_data = d; in_last = l; out_ready = r;
        ld = !m_valid || r;
        g = m_lock ? m_lock_ch : pick(v, m_ptr);
        m_rdy = (g >= 0 && ld) ? N'(1) << g : '0;
        if (g >= 0 && ld && v[g]) begin
            m_valid = 1; m_data = d[g*W +: W]; m_ch = g; m_last = l[g];
            if (LOCK_EN && !l[g]) begin
                m_lock = 1; m_lock_ch = g;
            end else begin
                m_lock = 0; m_ptr = (g + 1) % N;
            end
        end else if (r) begin
            m_valid = 0;
        end
        #2;
    endtask

    task automatic test_reset();
        logic [N*W-1:0] d;
        rst_n = 0; in_valid = '1; out_ready = 1; in_last = '1;
        #3;
        checks++; if (in_ready !== '0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0) begin errors++; $display("FAIL rst_out got v%b d%h c%0d exp 0", out_valid, out_data, out_ch); end
        tick();
        checks++; if (in_ready !== '0) begin errors++; $display("FAIL rst_hold_ready got %b exp 0", in_ready); end
        in_valid = '0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
        tick();
        d = $urandom;
        drive(4'b0100, d, '1, 1'b0);
        checks++; if (in_ready !== m_rdy) begin errors++; $display("FAIL rst_pre_ready got %b exp %b", in_ready, m_rdy); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd2) begin errors++; $display("FAIL rst_pre_beat got v%b c%0d exp v1 c2", out_valid, out_ch); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0) begin errors++; $display("FAIL rst_async got v%b d%h c%0d exp 0", out_valid, out_data, out_ch); end
        checks++; if (dut.ptr !== 2'd0) begin errors++; $display("FAIL rst_ptr got %0d exp 0", dut.ptr); end
        checks++; if (in_ready !== '0) begin errors++; $display("FAIL rst_mid_ready got %b exp 0", in_ready); end
        model_reset();
        in_valid = '0;
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_fairness();
        for (int k = 0; k < 8; k++) begin
            drive('1, $urandom, '1, 1'b1);
            checks++; if (in_ready !== m_rdy) begin errors++; $display("FAIL fair_ready%0d got %b exp %b", k, in_ready, m_rdy); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_ch !== 2'(k % 4)) begin errors++; $display("FAIL fair_ch%0d got v%b c%0d exp v1 c%0d", k, out_valid, out_ch, k % 4); end
            checks++; if (out_data !== m_data) begin errors++; $display("FAIL fair_data%0d got %h exp %h", k, out_data, m_data); end
        end
    endtask

    task automatic test_sparse();
        logic [N*W-1:0] d;
        d = $urandom; d[3*W +: W] = 8'hA3;
        drive(4'b1000, d, '1, 1'b1);
        tick();
        checks++; if (out_ch !== 2'd3 || out_data !== 8'hA3) begin errors++; $display("FAIL sparse_ch3 got c%0d d%h exp c3 dA3", out_ch, out_data); end
        d = $urandom; d[1*W +: W] = 8'hB1;
        drive(4'b0010, d, '1, 1'b1);
        tick();
        checks++; if (out_ch !== 2'd1 || out_data !== 8'hB1) begin errors++; $display("FAIL sparse_ch1 got c%0d d%h exp c1 dB1", out_ch, out_data); end
        checks++; if (dut.ptr !== 2'd2) begin errors++; $display("FAIL sparse_ptr got %0d exp 2", dut.ptr); end
    endtask

    task automatic test_idle();
        logic [1:0] p;
        p = 2'(m_ptr);
        for (int k = 0; k < 2; k++) begin
            drive('0, $urandom, '1, 1'b1);
            checks++; if (in_ready !== '0) begin errors++; $display("FAIL idle_ready got %b exp 0", in_ready); end
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", out_valid); end
            checks++; if (dut.ptr !== p) begin errors++; $display("FAIL idle_ptr got %0d exp %0d", dut.ptr, p); end
        end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] d0, d1;
        logic [W-1:0]   snap;
        d0 = $urandom;
        d1 = $urandom; d1[2*W +: W] = ~d0[2*W +: W];
        drive(4'b0100, d0, '1, 1'b0);
        tick();
        snap = d0[2*W +: W];
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== snap) begin errors++; $display("FAIL bp_first got v%b c%0d d%h exp v1 c2 d%h", out_valid, out_ch, out_data, snap); end
        for (int k = 0; k < 5; k++) begin
            drive(4'b0100, d1, '1, 1'b0);
            checks++; if (in_ready !== '0) begin errors++; $display("FAIL bp_ready%0d got %b exp 0", k, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== snap) begin errors++; $display("FAIL bp_hold%0d got v%b c%0d d%h exp v1 c2 d%h", k, out_valid, out_ch, out_data, snap); end
        end
        drive(4'b0100, d1, '1, 1'b1);
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b exp 0100", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== d1[2*W +: W]) begin errors++; $display("FAIL bp_release got v%b d%h exp v1 d%h", out_valid, out_data, d1[2*W +: W]); end
    endtask

`ifdef RR_MUX_LOCK_EN
    task automatic test_lock();
        logic [N-1:0] vs [6] = '{4'b0011, 4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0010};
        logic [N-1:0] ls [6] = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1111};
        int           chs [6] = '{0, -1, 0, -1, 0, 1};
        drive('0, '0, '1, 1'b1);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(vs[k], $urandom, ls[k], 1'b1);
            if (k < 5) begin
                checks++; if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL lock_ch1_ready%0d got %b exp 0", k, in_ready[1]); end
            end
            tick();
            checks++; if (out_valid !== (chs[k] >= 0)) begin errors++; $display("FAIL lock_valid%0d got %b exp %b", k, out_valid, chs[k] >= 0); end
            if (chs[k] >= 0) begin
                checks++; if (out_ch !== 2'(chs[k]) || out_data !== m_data) begin errors++; $display("FAIL lock_beat%0d got c%0d d%h exp c%0d d%h", k, out_ch, out_data, chs[k], m_data); end
            end
        end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL lock_last got %b exp 1", out_last); end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(N'($urandom), $urandom, LOCK_EN ? N'($urandom) : '1, $urandom_range(0, 3) != 0);
            checks++; if (in_ready !== m_rdy) begin errors++; $display("FAIL rand_ready%0d got %b exp %b", k, in_ready, m_rdy); end
            tick();
            checks++; if (out_valid !== m_valid || out_data !== m_data || out_ch !== 2'(m_ch)) begin errors++; $display("FAIL rand_out%0d got v%b d%h c%0d exp v%b d%h c%0d", k, out_valid, out_data, out_ch, m_valid, m_data, m_ch); end
`ifdef RR_MUX_LOCK_EN
            checks++; if (out_last !== m_last) begin errors++; $display("FAIL rand_last%0d got %b exp %b", k, out_last, m_last); end
`endif
            checks++; if (dut.ptr !== 2'(m_ptr)) begin errors++; $display("FAIL rand_ptr%0d got %0d exp %0d", k, dut.ptr, m_ptr); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fairness();
        test_sparse();
        test_idle();
        test_backpressure();
`ifdef RR_MUX_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule

// File: doc/rr_mux_m.md
# rr_mux_m

Registered N-channel round-robin multiplexer with valid/ready handshakes. It generalises the team's 2:1 combinational `mux_m` from fixed select to arbitrated selection across `N_CH` producers, and drives a single registered output stream. It sits between parallel producer channels and a shared downstream consumer. Fairness is guaranteed by a rotating priority pointer. Optional packet-lock mode keeps a channel granted for a whole multi-beat packet.

## Interface
Parameters:
- `WIDTH`, 8: data width per channel.
- `N_CH`, 4: number of input channels; must be at least 2.
- `CH_W`, `$clog2(N_CH)`: channel index width; derived, not overridden.

Ports (one clock; reset is asynchronous, active-low):
- `clk`: in, 1, clock; all logic is rising-edge.
- `rst_n`: in, 1, asynchronous active-low reset.
- `in_data`: in, `N_CH*WIDTH`, packed channel data; channel i is `[i*WIDTH +: WIDTH]`.
- `in_valid`: in, `N_CH`, per-channel valid.
- `in_ready`: out, `N_CH`, per-channel ready (combinational).
- `in_last`: in, `N_CH`, per-channel end-of-packet; present only with `RR_MUX_LOCK_EN`.
- `out_data`: out, `WIDTH`, registered selected data.
- `out_ch`: out, `CH_W`, registered index of the source channel.
- `out_last`: out, 1, registered end-of-packet; present only with `RR_MUX_LOCK_EN`.
- `out_valid`: out, 1, registered valid.
- `out_ready`: in, 1, downstream ready.

## Operation
- Handshake rules:
  - Output register can load: `load = !out_valid || out_ready`.
  - Grant is one-hot across channels.
  - `in_ready[i] = grant[i] && load`.
  - A beat on channel i transfers when `in_valid[i] && in_ready[i]`.
- Arbitration (state ARB):
  - Search valid channels starting at `ptr` and wrap modulo `N_CH`. The first valid channel found is granted.
  - If no channel is valid, there is no grant.
  - After each accepted beat, `ptr` becomes granted index + 1, wrapping from `N_CH-1` to 0.
  - `ptr` does not move when nothing is accepted.
- Output register:
  - On an accepted beat: `out_data`, `out_ch` (and `out_last`) load from the granted channel, and `out_valid` is set to 1.
  - If `out_ready` is high and no beat is accepted: `out_valid` is cleared to 0.
  - Otherwise the register holds its value.
  - Simultaneous drain and refill in the same cycle is allowed, giving full throughput.
- Stability: while `out_valid && !out_ready`, all output fields hold and every `in_ready` is 0.
- Channels that do not hold a grant see `in_ready` = 0 and must hold their data.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `out_last` = 0.
  - `ptr` = 0, state = ARB.
  - Asserting reset mid-operation discards the held beat and any in-progress lock immediately.

## Timing
- Latency: 1 cycle, from input acceptance to `out_valid` high.
- Throughput: 1 beat per cycle when `out_ready` is held high.
- `in_ready` combinationally depends on `out_ready`, `in_valid` and `ptr`/state. There is no combinational path from `in_data` to any output.
- Fairness: with all channels continuously valid, each channel is granted exactly once every `N_CH` accepted beats.
- Reset deassertion must be synchronised externally. The first grant is possible in the first clock after release.

## Configuration
- Macro: `RR_MUX_LOCK_EN`.
- Defined:
  - The block adds `in_last` and `out_last`, plus a two-state FSM with states ARB and LOCK.
  - ARB → LOCK: a beat is accepted with `in_last` = 0. The locked channel is the granted channel.
  - In LOCK, the grant is forced to the locked channel even if it is not valid. This causes a stall, not a switch.
  - LOCK → ARB: the locked channel's beat with `in_last` = 1 is accepted. `ptr` then advances past that channel.
  - `ptr` does not move during LOCK.
- Undefined: the ports are absent, the FSM stays permanently in ARB, and every beat is arbitrated independently.

## Structure
- Package `rr_mux_pkg`:
  - `typedef enum logic {ARB, LOCK} rr_state_t`.
  - Helper function `next_ptr(idx, n)` for the modulo increment.
- Sub-module `rr_arb_m`:
  - Purely combinational, parameterised by `N_CH`.
  - Inputs: `req`, `ptr`. Output: one-hot `grant` and its index.
  - Instantiated once.
  - `ptr` and the FSM registers stay in `rr_mux_m`.

## Test plan
- Reset: assert `rst_n` = 0 mid-stream with `out_valid` = 1. Required: `out_valid`, `out_data` and `out_ch` are 0 immediately; `ptr` = 0; all `in_ready` are 0 while in reset.
- Fairness: `N_CH` = 4, all valid, `out_ready` = 1, 8 beats. Required: `out_ch` sequence is 0,1,2,3,0,1,2,3, one beat per cycle.
- Sparse requests with wrap: only ch3 valid (data 0xA3), then only ch1 valid (0xB1). Required: `out_ch` 3 then 1, data 0xA3 then 0xB1; after ch1, `ptr` = 2.
- Backpressure: hold `out_ready` = 0 for 5 cycles with ch2 valid. Required: first beat registered; outputs stable; all `in_ready` 0; the next beat is accepted in the same cycle `out_ready` rises.
- Lock (`RR_MUX_LOCK_EN`): ch0 sends a 3-beat packet (`in_last` on beat 3) while ch1 is continuously valid. Required: `out_ch` is 0,0,0 then 1; ch1 `in_ready` stays 0 through the ch0 gap cycles.
- Idle: all `in_valid` 0 with `out_ready` = 1. Required: `out_valid` falls after the last beat drains; `ptr` unchanged.
